// File: rtl/mux8_pkg.sv
// Shared widths, FSM state type and select-order helpers for the mux8 serializer.
package mux8_pkg;

   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;
   localparam int GAP_W  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      GAPWAIT = 2'd2
   } ser_state_t;

   function automatic logic [SEL_W-1:0] first_sel(input logic lsb_first);
      return lsb_first ? SEL_W'(0) : SEL_W'(DATA_W - 1);
   endfunction

   function automatic logic [SEL_W-1:0] last_sel(input logic lsb_first);
      return lsb_first ? SEL_W'(DATA_W - 1) : SEL_W'(0);
   endfunction

endpackage

// File: rtl/mux8.sv
// Existing combinational 8:1 multiplexer: y is the data bit picked by select s.
module mux8 (
   input  logic [7:0] d,
   input  logic [2:0] s,
   output logic       y
);

   assign y = d[s];

endmodule

// File: rtl/mux8_serializer.sv
// Parallel-to-serial stage: holds an accepted word on mux8.d and walks mux8.s
// through all eight positions, one bit per downstream beat, with framing.
module mux8_serializer
   import mux8_pkg::*;
#(
   parameter bit          LSB_FIRST = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] d,
   output logic [SEL_W-1:0]  s,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              ser_last,
   input  logic              ser_ready
);

   localparam logic [SEL_W-1:0] FIRST    = first_sel(LSB_FIRST);
   localparam logic [SEL_W-1:0] LAST     = last_sel(LSB_FIRST);
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

   ser_state_t        state, state_nxt;
   logic [DATA_W-1:0] d_nxt;
   logic [SEL_W-1:0]  s_nxt;
   logic [GAP_W-1:0]  gap_cnt, gap_nxt;

   mux8 u_mux8 (
      .d (d),
      .s (s),
      .y (ser_out)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; mixing in blocking here would create simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         d       <= '0;
         s       <= '0;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         d       <= d_nxt;
         s       <= s_nxt;
         gap_cnt <= gap_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      d_nxt     = d;
      s_nxt     = s;
      gap_nxt   = gap_cnt;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_last  = 1'b0;

      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               d_nxt     = in_data;
               s_nxt     = FIRST;
               state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            ser_valid = 1'b1;
            ser_last  = (s == LAST);
            if (ser_ready) begin
               if (!ser_last) begin
                  s_nxt = LSB_FIRST ? s + 3'd1 : s - 3'd1;
               end else if (GAP == 0) begin
                  // Zero-gap reload keeps the link fully utilised across words.
                  in_ready = 1'b1;
                  if (in_valid) begin
                     d_nxt = in_data;
                     s_nxt = FIRST;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  gap_nxt   = GAP_LOAD;
                  state_nxt = GAPWAIT;
               end
            end
         end

         GAPWAIT: begin
            if (gap_cnt == '0) state_nxt = IDLE;
            else               gap_nxt   = gap_cnt - 4'd1;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux8_serializer.sv
// Bench for mux8_serializer: directed framing/timing checks plus randomized
// traffic scored against a bit-queue model, over three parameter sets.
module tb_mux8_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, ser_ready;
   logic [7:0] in_data;
   logic [1:0] cur;

   logic [2:0]      iv, sr, ir, so, sv, sl;
   logic [2:0][7:0] dd;
   logic [2:0][2:0] ss;

   logic       in_ready, ser_out, ser_valid, ser_last;
   logic [7:0] d;
   logic [2:0] s;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Instance 0: LSB first, GAP 0. Instance 1: MSB first, GAP 0. Instance 2: LSB first, GAP 3.
   mux8_serializer #(.LSB_FIRST(1'b1), .GAP(0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
      .d(dd[0]), .s(ss[0]), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .ser_ready(sr[0]));
   mux8_serializer #(.LSB_FIRST(1'b0), .GAP(0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
      .d(dd[1]), .s(ss[1]), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .ser_ready(sr[1]));
   mux8_serializer #(.LSB_FIRST(1'b1), .GAP(3)) dut_gap (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
      .d(dd[2]), .s(ss[2]), .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]), .ser_ready(sr[2]));

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         iv[i] = (int'(cur) == i) ? in_valid  : 1'b0;
         sr[i] = (int'(cur) == i) ? ser_ready : 1'b1;
      end
      in_ready  = ir[cur];
      ser_out   = so[cur];
      ser_valid = sv[cur];
      ser_last  = sl[cur];
      d         = dd[cur];
      s         = ss[cur];
   end

   function automatic bit cur_lsb();
      return cur != 2'd1;
   endfunction

   function automatic int cur_gap();
      return (cur == 2'd2) ? 3 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: each accepted word becomes eight {last,bit} entries in
   // transmit order; every downstream beat must pop the head entry.
   logic [1:0] exp_q[$];
   bit         stall_prev;
   logic       prev_out;
   logic [2:0] prev_s;
   logic [7:0] prev_d;
   int         gap_left;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_prev = 1'b0;
         gap_left   = 0;
      end else begin
         if (stall_prev) begin
            check("stall_out", 32'(ser_out), 32'(prev_out));
            check("stall_s",   32'(s),       32'(prev_s));
            check("stall_d",   32'(d),       32'(prev_d));
         end
         if (gap_left > 0) begin
            check("gap_valid", 32'(ser_valid), 32'd0);
            check("gap_ready", 32'(in_ready),  32'd0);
            gap_left--;
         end
         if (ser_valid && ser_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               logic [1:0] e;
               e = exp_q.pop_front();
               check("sb_bit",  32'(ser_out),  32'(e[0]));
               check("sb_last", 32'(ser_last), 32'(e[1]));
               if (e[1]) gap_left = cur_gap();
            end
         end
         if (in_valid && in_ready) begin
            for (int k = 0; k < 8; k++) begin
               int idx;
               idx = cur_lsb() ? k : 7 - k;
               exp_q.push_back({(k == 7) ? 1'b1 : 1'b0, in_data[idx]});
            end
         end
         stall_prev = ser_valid && !ser_ready;
         prev_out   = ser_out;
         prev_s     = s;
         prev_d     = d;
      end
   end

   initial begin
      logic [7:0] w;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      ser_ready = 1'b1;
      in_data   = 8'h00;
      cur       = 2'd0;

      // Reset state and release.
      step(); step();
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_ser_last",  32'(ser_last),  32'd0);
      check("rst_ser_out",   32'(ser_out),   32'd0);
      check("rst_s",         32'(s),         32'd0);
      check("rst_d",         32'(d),         32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_in_ready",  32'(in_ready),  32'd1);
      check("post_rst_ser_valid", 32'(ser_valid), 32'd0);

      // Single word, LSB first.
      w = 8'h7A;
      in_valid = 1'b1; in_data = w;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("lsb_valid", 32'(ser_valid), 32'd1);
         check("lsb_s",     32'(s),         32'(k));
         check("lsb_bit",   32'(ser_out),   32'((w >> k) & 8'd1));
         check("lsb_last",  32'(ser_last),  32'(k == 7));
         check("lsb_d",     32'(d),         32'(w));
         step();
      end
      check("lsb_idle_valid", 32'(ser_valid), 32'd0);
      check("lsb_idle_ready", 32'(in_ready),  32'd1);

      // MSB first.
      cur = 2'd1;
      w = 8'hA5;
      in_valid = 1'b1; in_data = w;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("msb_s",    32'(s),        32'(7 - k));
         check("msb_bit",  32'(ser_out),  32'((w >> (7 - k)) & 8'd1));
         check("msb_last", 32'(ser_last), 32'(k == 7));
         step();
      end
      check("msb_idle_valid", 32'(ser_valid), 32'd0);

      // Back-pressure on bit 4.
      cur = 2'd0;
      w = 8'h7A;
      in_valid = 1'b1; in_data = w;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            ser_ready = 1'b0;
            repeat (3) begin
               check("bp_s",     32'(s),         32'd4);
               check("bp_bit",   32'(ser_out),   32'd1);
               check("bp_valid", 32'(ser_valid), 32'd1);
               check("bp_in_ready", 32'(in_ready), 32'd0);
               step();
            end
            ser_ready = 1'b1;
         end
         check("bp_resume_s",   32'(s),       32'(k));
         check("bp_resume_bit", 32'(ser_out), 32'((w >> k) & 8'd1));
         step();
      end

      // Back-to-back, GAP 0: 16 contiguous bits.
      in_valid = 1'b1; in_data = 8'hFF;
      step();
      in_data = 8'h00;
      for (int c = 0; c < 16; c++) begin
         check("b2b_valid",    32'(ser_valid), 32'd1);
         check("b2b_bit",      32'(ser_out),   32'(c < 8));
         check("b2b_in_ready", 32'(in_ready),  32'((c % 8) == 7));
         if (c == 8) in_valid = 1'b0;
         step();
      end
      check("b2b_idle_valid", 32'(ser_valid), 32'd0);

      // GAP 3: three dead cycles plus one IDLE accept cycle between words.
      cur = 2'd2;
      in_valid = 1'b1; in_data = 8'h3C;
      step();
      in_data = 8'hC3;
      for (int c = 0; c < 20; c++) begin
         check("gap_ser_valid", 32'(ser_valid), 32'(c < 8 || c >= 12));
         check("gap_in_ready",  32'(in_ready),  32'(c == 11));
         if (c < 8)        check("gap_bit_w0", 32'(ser_out), 32'((8'h3C >> c) & 8'd1));
         else if (c >= 12) check("gap_bit_w1", 32'(ser_out), 32'((8'hC3 >> (c - 12)) & 8'd1));
         if (c == 12) in_valid = 1'b0;
         step();
      end
      repeat (6) step();

      // Mid-word reset at bit 5.
      cur = 2'd0;
      in_valid = 1'b1; in_data = 8'h7A;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      check("mrst_pre_s", 32'(s), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_in_ready",  32'(in_ready),  32'd1);
      check("mrst_ser_valid", 32'(ser_valid), 32'd0);
      check("mrst_ser_last",  32'(ser_last),  32'd0);
      check("mrst_ser_out",   32'(ser_out),   32'd0);
      check("mrst_s",         32'(s),         32'd0);
      check("mrst_d",         32'(d),         32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("mrst_idle_valid", 32'(ser_valid), 32'd0);
      check("mrst_idle_ready", 32'(in_ready),  32'd1);
      in_valid = 1'b1; in_data = 8'h81;
      step();
      in_valid = 1'b0;
      check("mrst_new_s",   32'(s),       32'd0);
      check("mrst_new_bit", 32'(ser_out), 32'd1);
      repeat (10) step();

      // Randomized traffic on every instance.
      for (int i = 0; i < 3; i++) begin
         int t;
         cur = 2'(i);
         for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = 8'($urandom);
            ser_ready = ($urandom_range(0, 9) < 7);
            step();
         end
         in_valid  = 1'b0;
         ser_ready = 1'b1;
         t = 0;
         while (exp_q.size() != 0 && t < 40) begin
            step();
            t++;
         end
         check("rand_drain", 32'(exp_q.size()), 32'd0);
         repeat (6) step();
         check("rand_idle_valid", 32'(ser_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
